// File: rtl/ipsxb_ddr_rst_seq_v1_0_if.sv
// Status and reset-control bundle between the DDR reset sequencer and its surroundings.
// Inputs are expected to be already synchronised to the sequencer clock.
interface ipsxb_ddr_rst_seq_v1_0_if;
   logic       pll_lock;
   logic       init_done;
   logic       soft_rst_req;
   logic       phy_rst_n;
   logic       ctrl_rst_n;
   logic       init_start;
   logic       seq_done;
   logic       init_timeout;
   logic [2:0] seq_state;

   modport slave (
      input  pll_lock, init_done, soft_rst_req,
      output phy_rst_n, ctrl_rst_n, init_start, seq_done, init_timeout, seq_state
   );

   modport master (
      output pll_lock, init_done, soft_rst_req,
      input  phy_rst_n, ctrl_rst_n, init_start, seq_done, init_timeout, seq_state
   );
endinterface

// File: rtl/ipsxb_ddr_rst_seq_v1_0.sv
// DDR3 reset sequencer: qualifies PLL lock, releases PHY then controller, kicks off init
// and waits for completion; lock loss, soft reset or init timeout fall back to reset.
module ipsxb_ddr_rst_seq_v1_0 #(
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int PHY_RST_CYC      = 64,
   parameter int INIT_TIMEOUT_CYC = 500000,
   parameter int CNT_W            = 20
) (
   input  logic                          clk,
   input  logic                          rst_n,
   ipsxb_ddr_rst_seq_v1_0_if.slave       bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PHY_REL   = 3'd1,
      CTRL_REL  = 3'd2,
      WAIT_INIT = 3'd3,
      DONE      = 3'd4,
      TIMEOUT   = 3'd5
   } state_e;

   localparam int LS_EFF = (LOCK_STABLE_CYC == 0) ? 1 : LOCK_STABLE_CYC;
   localparam int PR_EFF = (PHY_RST_CYC == 0) ? 1 : PHY_RST_CYC;
   localparam int TO_EFF = (INIT_TIMEOUT_CYC == 0) ? 1 : INIT_TIMEOUT_CYC;
   localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LS_EFF - 1);
   localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PR_EFF - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EFF - 1);
   localparam bit               TO_EN   = (INIT_TIMEOUT_CYC != 0);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             abort;
   logic             phy_rst_n_q, phy_rst_n_d;
   logic             ctrl_rst_n_q, ctrl_rst_n_d;
   logic             init_start_q, init_start_d;
   logic             seq_done_q, seq_done_d;
   logic             init_timeout_q, init_timeout_d;

   always_comb begin
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      abort   = bus.soft_rst_req | (~bus.pll_lock & (state_q != IDLE));
      state_d = state_q;
      cnt_d   = cnt_q;
      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!bus.pll_lock) begin
                  cnt_d = '0;
               end else if (cnt_q >= LS_LAST) begin
                  state_d = PHY_REL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            PHY_REL: begin
               if (cnt_q >= PR_LAST) begin
                  state_d = CTRL_REL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            CTRL_REL: begin
               // The init_start cycle itself is count 0, so WAIT_INIT begins at 1.
               state_d = WAIT_INIT;
               cnt_d   = CNT_W'(1);
            end
            WAIT_INIT: begin
               if (bus.init_done) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else if (TO_EN && (cnt_q >= TO_LAST)) begin
                  state_d = TIMEOUT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            DONE, TIMEOUT: cnt_d = '0;
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      phy_rst_n_d    = (state_d != IDLE);
      ctrl_rst_n_d   = (state_d == CTRL_REL) || (state_d == WAIT_INIT) || (state_d == DONE);
      init_start_d   = (state_d == CTRL_REL);
      seq_done_d     = (state_d == DONE);
      init_timeout_d = (state_d == TIMEOUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         phy_rst_n_q    <= 1'b0;
         ctrl_rst_n_q   <= 1'b0;
         init_start_q   <= 1'b0;
         seq_done_q     <= 1'b0;
         init_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         phy_rst_n_q    <= phy_rst_n_d;
         ctrl_rst_n_q   <= ctrl_rst_n_d;
         init_start_q   <= init_start_d;
         seq_done_q     <= seq_done_d;
         init_timeout_q <= init_timeout_d;
      end
   end

   assign bus.phy_rst_n    = phy_rst_n_q;
   assign bus.ctrl_rst_n   = ctrl_rst_n_q;
   assign bus.init_start   = init_start_q;
   assign bus.seq_done     = seq_done_q;
   assign bus.init_timeout = init_timeout_q;
   assign bus.seq_state    = state_q;

endmodule

// File: tb/tb_ipsxb_ddr_rst_seq_v1_0.sv
// Directed bench for the DDR reset sequencer: lock qualification, release timing,
// init completion, timeout, abort priority and asynchronous reset.
module tb_ipsxb_ddr_rst_seq_v1_0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   ipsxb_ddr_rst_seq_v1_0_if bus();

   ipsxb_ddr_rst_seq_v1_0 #(
      .LOCK_STABLE_CYC  (1024),
      .PHY_RST_CYC      (64),
      .INIT_TIMEOUT_CYC (100),
      .CNT_W            (20)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance n active edges and settle just after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_all0(input string tag);
      chk({tag, ".phy"},   bus.phy_rst_n,    0);
      chk({tag, ".ctrl"},  bus.ctrl_rst_n,   0);
      chk({tag, ".start"}, bus.init_start,   0);
      chk({tag, ".done"},  bus.seq_done,     0);
      chk({tag, ".tmo"},   bus.init_timeout, 0);
      chk({tag, ".state"}, bus.seq_state,    0);
   endtask

   initial begin
      bus.pll_lock     = 1'b0;
      bus.init_done    = 1'b0;
      bus.soft_rst_req = 1'b0;

      // Reset state
      #12;
      chk_all0("rst");
      tick(1);
      rst_n = 1'b1;
      tick(3);
      chk_all0("idle_nolock");

      // Clean lock: phy at 1024, ctrl/init_start at 1088
      bus.pll_lock = 1'b1;
      tick(1023);
      chk("lock.phy_pre", bus.phy_rst_n, 0);
      chk("lock.st_pre", bus.seq_state, 0);
      tick(1);
      chk("lock.phy_rise", bus.phy_rst_n, 1);
      chk("lock.st_phy", bus.seq_state, 1);
      chk("lock.ctrl_lo", bus.ctrl_rst_n, 0);
      tick(63);
      chk("phy.ctrl_pre", bus.ctrl_rst_n, 0);
      chk("phy.start_pre", bus.init_start, 0);
      tick(1);
      chk("ctrl.rise", bus.ctrl_rst_n, 1);
      chk("ctrl.start", bus.init_start, 1);
      chk("ctrl.st", bus.seq_state, 2);
      tick(1);
      chk("wait.start_lo", bus.init_start, 0);
      chk("wait.st", bus.seq_state, 3);
      chk("wait.ctrl", bus.ctrl_rst_n, 1);

      // init_done 10 cycles after init_start
      tick(9);
      bus.init_done = 1'b1;
      chk("wait.not_done", bus.seq_done, 0);
      tick(1);
      chk("done.seq", bus.seq_done, 1);
      chk("done.st", bus.seq_state, 4);
      bus.init_done = 1'b0;
      tick(5);
      chk("done.hold", bus.seq_done, 1);
      chk("done.phy", bus.phy_rst_n, 1);
      chk("done.ctrl", bus.ctrl_rst_n, 1);

      // Lock loss together with init_done in DONE
      bus.pll_lock  = 1'b0;
      bus.init_done = 1'b1;
      tick(1);
      chk_all0("done_abort");
      bus.init_done = 1'b0;

      // Lock glitch at 500 restarts qualification
      bus.pll_lock = 1'b1;
      tick(500);
      bus.pll_lock = 1'b0;
      tick(1);
      chk("glitch.st", bus.seq_state, 0);
      bus.pll_lock = 1'b1;
      tick(1023);
      chk("glitch.phy_pre", bus.phy_rst_n, 0);
      tick(1);
      chk("glitch.phy_rise", bus.phy_rst_n, 1);

      // Early init_done is ignored outside WAIT_INIT
      bus.init_done = 1'b1;
      tick(10);
      chk("early.st", bus.seq_state, 1);
      chk("early.done", bus.seq_done, 0);
      bus.init_done = 1'b0;
      tick(54);
      chk("tmo.start", bus.init_start, 1);

      // Timeout 100 cycles after init_start
      tick(99);
      chk("tmo.st_pre", bus.seq_state, 3);
      chk("tmo.flag_pre", bus.init_timeout, 0);
      tick(1);
      chk("tmo.st", bus.seq_state, 5);
      chk("tmo.flag", bus.init_timeout, 1);
      chk("tmo.ctrl", bus.ctrl_rst_n, 0);
      chk("tmo.phy", bus.phy_rst_n, 1);
      tick(20);
      chk("tmo.hold", bus.seq_state, 5);

      // Soft reset pulse leaves TIMEOUT, sequence restarts
      bus.soft_rst_req = 1'b1;
      tick(1);
      bus.soft_rst_req = 1'b0;
      chk_all0("soft");
      tick(1023);
      chk("soft.phy_pre", bus.phy_rst_n, 0);
      tick(1);
      chk("soft.phy_rise", bus.phy_rst_n, 1);
      tick(64);
      chk("soft.start", bus.init_start, 1);

      // Abort beats same-cycle init_done in WAIT_INIT
      tick(1);
      bus.soft_rst_req = 1'b1;
      bus.init_done    = 1'b1;
      tick(1);
      chk("prio.st", bus.seq_state, 0);
      chk("prio.done", bus.seq_done, 0);
      bus.init_done = 1'b0;

      // Held soft reset keeps IDLE with lock high
      tick(1500);
      chk("held.st", bus.seq_state, 0);
      chk("held.phy", bus.phy_rst_n, 0);
      bus.soft_rst_req = 1'b0;
      tick(1024);
      chk("held.phy_rise", bus.phy_rst_n, 1);

      // Async reset mid-PHY_REL
      tick(10);
      rst_n = 1'b0;
      #2;
      chk_all0("async");
      rst_n = 1'b1;
      tick(1023);
      chk("async.phy_pre", bus.phy_rst_n, 0);
      tick(1);
      chk("async.phy_rise", bus.phy_rst_n, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
